jt51_timer_bank: RTL and testbench

//  NCH independent prescaled up-counting timers with sticky flags and a shared active-low IRQ.

---
 rtl/jt51_timer_pkg.sv | 18 +
 rtl/jt51_timer_ch.sv | 110 +++++++++++
 rtl/jt51_timer_bank.sv | 52 +++++
 tb/tb_jt51_timer_bank.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/jt51_timer_pkg.sv
// Shared defaults for the jt51 timer bank and the prescaler-select clamp.
package jt51_timer_pkg;

    localparam int CW_DEFAULT = 10;
    localparam int PW_DEFAULT = 10;
    localparam int DW_DEFAULT = 4;

    function automatic logic [31:0] clamp_presc(input logic [31:0] presc, input logic [31:0] pw);
        logic [31:0] res;
        if (presc > pw) begin
            res = pw;
        end else begin
            res = presc;
        end
        return res;
    endfunction

endpackage

// File: rtl/jt51_timer_ch.sv
// One prescaled up-counting timer: prescaler, counter, run state, sticky flag, overflow pulse.
module jt51_timer_ch
    import jt51_timer_pkg::*;
#(
    parameter int CW = CW_DEFAULT,
    parameter int PW = PW_DEFAULT,
    parameter int DW = DW_DEFAULT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [CW-1:0] start_value,
    input  logic [DW-1:0] presc,
    input  logic          load,
    input  logic          set_run,
    input  logic          clr_run,
    input  logic          clr_flag,
    input  logic          oneshot,
    output logic          flag,
    output logic          overflow,
    output logic [CW-1:0] cnt
);

    logic [PW-1:0] mult_r;
    logic [CW-1:0] cnt_r;
    logic          run_r;
    logic          flag_r;
    logic          overflow_r;

    logic [31:0]   d_s;
    logic [PW-1:0] mask_s;
    logic          tick_s;
    logic          wrap_s;
    logic [PW-1:0] mult_nx_s;
    logic [CW-1:0] cnt_nx_s;
    logic          run_nx_s;
    logic          flag_nx_s;

    // Next-state logic: load beats counting; run priority clr_run > set_run/load > oneshot stop.
    always_comb begin
        d_s       = clamp_presc(32'(presc), 32'(PW));
        mask_s    = {PW{1'b0}};
        for (int i = 0; i < PW; i++) begin
            mask_s[i] = (32'(i) < d_s);
        end
        tick_s    = ((mult_r & mask_s) == mask_s);
        wrap_s    = 1'b0;
        mult_nx_s = mult_r;
        cnt_nx_s  = cnt_r;

        if (load) begin
            cnt_nx_s  = start_value;
            mult_nx_s = {PW{1'b0}};
        end else if (run_r) begin
            if (!tick_s) begin
                // Masking keeps bits above the current division at zero after a presc change.
                mult_nx_s = (mult_r + {{(PW-1){1'b0}}, 1'b1}) & mask_s;
            end else if (cnt_r != {CW{1'b1}}) begin
                cnt_nx_s  = cnt_r + {{(CW-1){1'b0}}, 1'b1};
                mult_nx_s = {PW{1'b0}};
            end else begin
                cnt_nx_s  = start_value;
                mult_nx_s = {PW{1'b0}};
                wrap_s    = 1'b1;
            end
        end else begin
            mult_nx_s = mult_r;
            cnt_nx_s  = cnt_r;
        end

        if (clr_run) begin
            run_nx_s = 1'b0;
        end else if (set_run || load) begin
            run_nx_s = 1'b1;
        end else if (wrap_s && oneshot) begin
            run_nx_s = 1'b0;
        end else begin
            run_nx_s = run_r;
        end

        if (clr_flag) begin
            flag_nx_s = 1'b0;
        end else if (overflow_r) begin
            flag_nx_s = 1'b1;
        end else begin
            flag_nx_s = flag_r;
        end
    end

    // State registers; the overflow pulse is the registered wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mult_r     <= {PW{1'b0}};
            cnt_r      <= {CW{1'b0}};
            run_r      <= 1'b0;
            flag_r     <= 1'b0;
            overflow_r <= 1'b0;
        end else begin
            mult_r     <= mult_nx_s;
            cnt_r      <= cnt_nx_s;
            run_r      <= run_nx_s;
            flag_r     <= flag_nx_s;
            overflow_r <= wrap_s;
        end
    end

    assign flag     = flag_r;
    assign overflow = overflow_r;
    assign cnt      = cnt_r;

endmodule

// File: rtl/jt51_timer_bank.sv
// NCH independent jt51-style timers with sticky flags and a shared active-low interrupt.
module jt51_timer_bank
    import jt51_timer_pkg::*;
#(
    parameter int NCH = 2,
    parameter int CW  = CW_DEFAULT,
    parameter int PW  = PW_DEFAULT,
    parameter int DW  = DW_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NCH*CW-1:0] start_value,
    input  logic [NCH*DW-1:0] presc,
    input  logic [NCH-1:0]    load,
    input  logic [NCH-1:0]    set_run,
    input  logic [NCH-1:0]    clr_run,
    input  logic [NCH-1:0]    clr_flag,
    input  logic [NCH-1:0]    oneshot,
    input  logic [NCH-1:0]    irq_en,
    output logic [NCH-1:0]    flag,
    output logic [NCH-1:0]    overflow,
    output logic [NCH*CW-1:0] cnt_out,
    output logic              irq_n
);

    genvar g;
    generate
        for (g = 0; g < NCH; g++) begin : g_ch
            jt51_timer_ch #(
                .CW (CW),
                .PW (PW),
                .DW (DW)
            ) u_ch (
                .clk         (clk),
                .rst         (rst),
                .start_value (start_value[g*CW +: CW]),
                .presc       (presc[g*DW +: DW]),
                .load        (load[g]),
                .set_run     (set_run[g]),
                .clr_run     (clr_run[g]),
                .clr_flag    (clr_flag[g]),
                .oneshot     (oneshot[g]),
                .flag        (flag[g]),
                .overflow    (overflow[g]),
                .cnt         (cnt_out[g*CW +: CW])
            );
        end
    endgenerate

    assign irq_n = ~|(flag & irq_en);

endmodule

// File: tb/tb_jt51_timer_bank.sv
// Directed bench for jt51_timer_bank: overflow pulses checked against a per-channel cycle scoreboard.
module tb_jt51_timer_bank;

    localparam int NCH = 2;
    localparam int CW  = 4;
    localparam int PW  = 10;
    localparam int DW  = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic [NCH*CW-1:0] start_value;
    logic [NCH*DW-1:0] presc;
    logic [NCH-1:0]    load, set_run, clr_run, clr_flag, oneshot, irq_en;
    logic [NCH-1:0]    flag, overflow;
    logic [NCH*CW-1:0] cnt_out;
    logic              irq_n;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int exp_q [NCH][$];
    int t0, t1;

    jt51_timer_bank #(.NCH(NCH), .CW(CW), .PW(PW), .DW(DW)) dut (
        .clk         (clk),
        .rst         (rst),
        .start_value (start_value),
        .presc       (presc),
        .load        (load),
        .set_run     (set_run),
        .clr_run     (clr_run),
        .clr_flag    (clr_flag),
        .oneshot     (oneshot),
        .irq_en      (irq_en),
        .flag        (flag),
        .overflow    (overflow),
        .cnt_out     (cnt_out),
        .irq_n       (irq_n)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every overflow pulse must match the next expected cycle for its channel.
    always @(negedge clk) begin
        int e;
        if (!rst) begin
            for (int ch = 0; ch < NCH; ch++) begin
                if (overflow[ch]) begin
                    checks++;
                    if (exp_q[ch].size() == 0) begin
                        errors++;
                        $display("FAIL overflow_unexpected ch%0d: pulse at cycle %0d, none expected", ch, cyc);
                    end else begin
                        e = exp_q[ch].pop_front();
                        if (e != cyc) begin
                            errors++;
                            $display("FAIL overflow_time ch%0d: pulse at cycle %0d, expected cycle %0d", ch, cyc, e);
                        end
                    end
                end else if (exp_q[ch].size() > 0 && exp_q[ch][0] < cyc) begin
                    checks++;
                    errors++;
                    e = exp_q[ch].pop_front();
                    $display("FAIL overflow_missed ch%0d: no pulse by cycle %0d, expected cycle %0d", ch, cyc, e);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    initial begin
        rst         = 1'b1;
        start_value = '0;
        presc       = '0;
        load        = '0;
        set_run     = '0;
        clr_run     = '0;
        clr_flag    = '0;
        oneshot     = '0;
        irq_en      = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("reset_cnt", 32'(cnt_out), 32'd0);
        chk("reset_flag", 32'(flag), 32'd0);
        chk("reset_overflow", 32'(overflow), 32'd0);
        chk("reset_irq_n", 32'(irq_n), 32'd1);
        step();

        // 1: start=14, presc=0 -> overflow 3 cycles after load, then every 2
        start_value[3:0] = 4'd14;
        presc[3:0] = 4'd0;
        load = 2'b01;
        t0 = cyc;
        exp_q[0].push_back(t0 + 3);
        exp_q[0].push_back(t0 + 5);
        exp_q[0].push_back(t0 + 7);
        step(); load = 2'b00;
        chk("t1_cnt_after_load", 32'(cnt_out[3:0]), 32'd14);
        step(); chk("t1_cnt_inc", 32'(cnt_out[3:0]), 32'd15);
        step(); chk("t1_cnt_wrap", 32'(cnt_out[3:0]), 32'd14);
        step(); chk("t1_flag_set", 32'(flag), 32'd1);
        chk("t1_irq_masked", 32'(irq_n), 32'd1);
        step(); step(); step();
        clr_run = 2'b01;
        step(); clr_run = 2'b00;
        chk("t1_cnt_stop", 32'(cnt_out[3:0]), 32'd15);
        repeat (4) step();
        chk("t1_cnt_held", 32'(cnt_out[3:0]), 32'd15);
        clr_flag = 2'b01;
        step(); clr_flag = 2'b00;
        chk("t1_flag_clr", 32'(flag), 32'd0);

        // 2: presc=3, start=15 -> wrap 8 cycles after load, one-cycle pulse, sticky flag
        presc[3:0] = 4'd3;
        start_value[3:0] = 4'd15;
        load = 2'b01;
        t0 = cyc;
        exp_q[0].push_back(t0 + 9);
        step(); load = 2'b00;
        chk("t2_cnt_load", 32'(cnt_out[3:0]), 32'd15);
        repeat (7) step();
        chk("t2_no_early_ovf", 32'(overflow), 32'd0);
        step(); chk("t2_ovf_pulse", 32'(overflow), 32'd1);
        step(); chk("t2_ovf_one_cycle", 32'(overflow), 32'd0);
        chk("t2_flag_set", 32'(flag), 32'd1);
        clr_run = 2'b01;
        step(); clr_run = 2'b00;
        repeat (3) step();
        chk("t2_flag_sticky", 32'(flag), 32'd1);
        clr_flag = 2'b01;
        step(); clr_flag = 2'b00;

        // 3: oneshot, start=12 -> single overflow, count held, set_run resumes
        presc[3:0] = 4'd0;
        oneshot = 2'b01;
        start_value[3:0] = 4'd12;
        load = 2'b01;
        t0 = cyc;
        exp_q[0].push_back(t0 + 5);
        step(); load = 2'b00;
        repeat (4) step();
        chk("t3_cnt_reload", 32'(cnt_out[3:0]), 32'd12);
        repeat (5) step();
        chk("t3_cnt_held", 32'(cnt_out[3:0]), 32'd12);
        set_run = 2'b01;
        t1 = cyc;
        exp_q[0].push_back(t1 + 5);
        step(); set_run = 2'b00;
        step(); chk("t3_resumed", 32'(cnt_out[3:0]), 32'd13);
        repeat (3) step();
        repeat (3) step();
        chk("t3_cnt_held2", 32'(cnt_out[3:0]), 32'd12);
        oneshot = 2'b00;
        clr_flag = 2'b01;
        step(); clr_flag = 2'b00;

        // 4: clr_flag coinciding with overflow wins; irq_n follows flag & irq_en
        start_value[3:0] = 4'd14;
        oneshot = 2'b01;
        load = 2'b01;
        t0 = cyc;
        exp_q[0].push_back(t0 + 3);
        step(); load = 2'b00;
        step(); step();
        clr_flag = 2'b01;
        step(); clr_flag = 2'b00;
        chk("t4_clr_wins", 32'(flag), 32'd0);
        step(); chk("t4_clr_wins_hold", 32'(flag), 32'd0);
        irq_en = 2'b01;
        set_run = 2'b01;
        t1 = cyc;
        exp_q[0].push_back(t1 + 3);
        step(); set_run = 2'b00;
        repeat (3) step();
        chk("t4_flag_set", 32'(flag), 32'd1);
        chk("t4_irq_asserted", 32'(irq_n), 32'd0);
        irq_en = 2'b00;
        #1 chk("t4_irq_masked", 32'(irq_n), 32'd1);
        oneshot = 2'b00;
        clr_flag = 2'b01;
        step(); clr_flag = 2'b00;

        // 5: clr_run + set_run + load together -> reloaded but stopped
        start_value[3:0] = 4'd9;
        load = 2'b01;
        step(); load = 2'b00;
        chk("t5_cnt_load", 32'(cnt_out[3:0]), 32'd9);
        step(); step();
        chk("t5_cnt_run", 32'(cnt_out[3:0]), 32'd11);
        clr_run = 2'b01; set_run = 2'b01; load = 2'b01;
        step(); clr_run = 2'b00; set_run = 2'b00; load = 2'b00;
        chk("t5_cnt_reloaded", 32'(cnt_out[3:0]), 32'd9);
        step(); step();
        chk("t5_stopped", 32'(cnt_out[3:0]), 32'd9);

        // 6: both channels, different prescalers, same overflow cycle; then async reset mid-count
        irq_en = 2'b11;
        start_value = {4'd14, 4'd12};
        presc = {4'd2, 4'd1};
        load = 2'b11;
        t0 = cyc;
        for (int ch = 0; ch < NCH; ch++) begin
            exp_q[ch].push_back(t0 + 9);
            exp_q[ch].push_back(t0 + 17);
        end
        step(); load = 2'b00;
        repeat (8) step();
        chk("t6_both_ovf", 32'(overflow), 32'd3);
        chk("t6_irq_before_flag", 32'(irq_n), 32'd1);
        step(); chk("t6_both_flags", 32'(flag), 32'd3);
        chk("t6_irq", 32'(irq_n), 32'd0);
        repeat (7) step();
        step();
        chk("t6_cnt_running", 32'(cnt_out), 32'hE_C);
        #2 rst = 1'b1;
        #1;
        chk("rst_mid_cnt", 32'(cnt_out), 32'd0);
        chk("rst_mid_flag", 32'(flag), 32'd0);
        chk("rst_mid_overflow", 32'(overflow), 32'd0);
        chk("rst_mid_irq_n", 32'(irq_n), 32'd1);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (10) step();
        chk("post_rst_cnt", 32'(cnt_out), 32'd0);
        chk("post_rst_flag", 32'(flag), 32'd0);

        for (int ch = 0; ch < NCH; ch++) begin
            chk($sformatf("pending_ovf_ch%0d", ch), 32'(exp_q[ch].size()), 32'd0);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
